// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU sequencer/arbiter: opcodes, FSM states, flag payload.
package alu_ctrl_pkg;

    localparam int unsigned OP_W   = 4;
    localparam int unsigned MAX_OP = 7;

    localparam logic [OP_W-1:0] OP_AND  = 4'd0;
    localparam logic [OP_W-1:0] OP_OR   = 4'd1;
    localparam logic [OP_W-1:0] OP_ADD  = 4'd2;
    localparam logic [OP_W-1:0] OP_SUB  = 4'd3;
    localparam logic [OP_W-1:0] OP_XOR  = 4'd4;
    localparam logic [OP_W-1:0] OP_NOR  = 4'd5;
    localparam logic [OP_W-1:0] OP_NAND = 4'd6;
    localparam logic [OP_W-1:0] OP_SLT  = 4'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic is_zero;
        logic is_negative;
        logic ovfl;
        logic err;
    } flags_t;

    // Only arithmetic opcodes carry a meaningful overflow flag.
    function automatic logic op_sets_ovfl(input logic [OP_W-1:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_SLT);
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter; last_grant advances only when update is asserted.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    input  logic       update,
    output logic [1:0] grant_c,
    output logic       grant_id_c
);

    logic last_grant;

    // Reset to port 1 so port 0 wins the first contention.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (update) begin
            last_grant <= grant_id_c;
        end
    end

    always_comb begin
        grant_id_c = valid[1];
        if (valid == 2'b11) begin
            grant_id_c = ~last_grant;
        end
        grant_c = {valid[1] & grant_id_c, valid[0] & ~grant_id_c};
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sequencer for the shared combinational ALU: accept, execute for one cycle,
// then hold a tagged registered response until the consumer takes it.
module alu_arbiter #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned MAX_OP = alu_ctrl_pkg::MAX_OP
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_A,
    input  logic [WIDTH-1:0] req0_B,
    input  logic [3:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_A,
    input  logic [WIDTH-1:0] req1_B,
    input  logic [3:0]       req1_op,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [WIDTH-1:0] resp_R,
    output logic             resp_isZero,
    output logic             resp_isNegative,
    output logic             resp_ovfl,
    output logic             resp_err,
    output logic [WIDTH-1:0] alu_A,
    output logic [WIDTH-1:0] alu_B,
    output logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] alu_R,
    input  logic             alu_isZero,
    input  logic             alu_isNegative,
    input  logic             alu_ovfl
);

    import alu_ctrl_pkg::*;

    state_t           state;
    state_t           state_nxt;
    logic [1:0]       grant_c;
    logic             grant_id_c;
    logic             accept_c;
    logic             op_illegal_c;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [3:0]       op_q;
    logic             id_q;
    logic             rsp_valid_q;
    logic             rsp_id_q;
    logic [WIDTH-1:0] rsp_r_q;
    flags_t           rsp_flags_q;

    // Requests are only offered to the arbiter in IDLE; reset overrides any handshake.
    rr_arbiter2 u_arb (
        .clk        (CLK),
        .rst        (Reset),
        .valid      ({req1_valid, req0_valid} & {2{(state == IDLE) && !Reset}}),
        .update     (accept_c),
        .grant_c    (grant_c),
        .grant_id_c (grant_id_c)
    );

    assign req0_ready   = grant_c[0];
    assign req1_ready   = grant_c[1];
    assign accept_c     = |grant_c;
    assign op_illegal_c = 32'(op_q) > MAX_OP;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept_c)   state_nxt = EXEC;
            EXEC:                    state_nxt = RESP;
            RESP:    if (resp_ready) state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    // Operand capture from the winning port.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            a_q  <= '0;
            b_q  <= '0;
            op_q <= '0;
            id_q <= 1'b0;
        end else if (accept_c) begin
            a_q  <= grant_id_c ? req1_A  : req0_A;
            b_q  <= grant_id_c ? req1_B  : req0_B;
            op_q <= grant_id_c ? req1_op : req0_op;
            id_q <= grant_id_c;
        end
    end

    // Response capture at the end of EXEC; illegal opcodes report only err.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_r_q     <= '0;
            rsp_flags_q <= '0;
        end else if (state == EXEC) begin
            rsp_valid_q <= 1'b1;
            rsp_id_q    <= id_q;
            if (op_illegal_c) begin
                rsp_r_q     <= '0;
                rsp_flags_q <= '{is_zero: 1'b0, is_negative: 1'b0, ovfl: 1'b0, err: 1'b1};
            end else begin
                rsp_r_q     <= alu_R;
                rsp_flags_q <= '{is_zero:     alu_isZero,
                                 is_negative: alu_isNegative,
                                 ovfl:        alu_ovfl & op_sets_ovfl(op_q),
                                 err:         1'b0};
            end
        end else if ((state == RESP) && resp_ready) begin
            rsp_valid_q <= 1'b0;
        end
    end

    assign alu_A           = a_q;
    assign alu_B           = b_q;
    assign alu_op          = ((state == EXEC) && !op_illegal_c) ? op_q : 4'd0;
    assign resp_valid      = rsp_valid_q;
    assign resp_id         = rsp_id_q;
    assign resp_R          = rsp_r_q;
    assign resp_isZero     = rsp_flags_q.is_zero;
    assign resp_isNegative = rsp_flags_q.is_negative;
    assign resp_ovfl       = rsp_flags_q.ovfl;
    assign resp_err        = rsp_flags_q.err;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU and an expected-response queue.
module tb_alu_arbiter;

    localparam int unsigned W = 16;

    logic         CLK = 1'b0;
    logic         Reset = 1'b1;
    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic         req0_ready, req1_ready;
    logic [W-1:0] req0_A = '0, req0_B = '0, req1_A = '0, req1_B = '0;
    logic [3:0]   req0_op = '0, req1_op = '0;
    logic         resp_valid, resp_ready = 1'b0, resp_id;
    logic [W-1:0] resp_R;
    logic         resp_isZero, resp_isNegative, resp_ovfl, resp_err;
    logic [W-1:0] alu_A, alu_B, alu_R;
    logic [3:0]   alu_op;
    logic         alu_isZero, alu_isNegative, alu_ovfl;
    logic         stale_ovfl = 1'b0;

    typedef struct packed {
        logic         id;
        logic [W-1:0] r;
        logic         z;
        logic         n;
        logic         o;
        logic         e;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail = 0;

    always #5 CLK = ~CLK;

    alu_arbiter dut (
        .CLK(CLK), .Reset(Reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_A(req0_A), .req0_B(req0_B), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_A(req1_A), .req1_B(req1_B), .req1_op(req1_op),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id), .resp_R(resp_R),
        .resp_isZero(resp_isZero), .resp_isNegative(resp_isNegative), .resp_ovfl(resp_ovfl), .resp_err(resp_err),
        .alu_A(alu_A), .alu_B(alu_B), .alu_op(alu_op), .alu_R(alu_R),
        .alu_isZero(alu_isZero), .alu_isNegative(alu_isNegative), .alu_ovfl(alu_ovfl)
    );

    // Behavioural 16-bit ALU; stale_ovfl mimics a leftover overflow indication.
    logic [W-1:0] m_sum, m_diff, m_r;
    logic         m_ovfl;
    always_comb begin
        m_sum  = alu_A + alu_B;
        m_diff = alu_A - alu_B;
        m_r    = '0;
        m_ovfl = 1'b0;
        case (alu_op)
            4'd0: m_r = alu_A & alu_B;
            4'd1: m_r = alu_A | alu_B;
            4'd2: begin m_r = m_sum;  m_ovfl = (alu_A[W-1] == alu_B[W-1]) && (m_sum[W-1] != alu_A[W-1]); end
            4'd3: begin m_r = m_diff; m_ovfl = (alu_A[W-1] != alu_B[W-1]) && (m_diff[W-1] != alu_A[W-1]); end
            4'd4: m_r = alu_A ^ alu_B;
            4'd5: m_r = ~(alu_A | alu_B);
            4'd6: m_r = ~(alu_A & alu_B);
            4'd7: begin
                m_r    = ($signed(alu_A) < $signed(alu_B)) ? 16'd1 : 16'd0;
                m_ovfl = (alu_A[W-1] != alu_B[W-1]) && (m_diff[W-1] != alu_A[W-1]);
            end
            default: m_r = '0;
        endcase
    end
    assign alu_R          = m_r;
    assign alu_isZero     = (m_r == '0);
    assign alu_isNegative = m_r[W-1];
    assign alu_ovfl       = m_ovfl | stale_ovfl;

    function automatic exp_t mk(input logic id, input logic [W-1:0] r,
                                input logic z, input logic n, input logic o, input logic e);
        exp_t x;
        x.id = id; x.r = r; x.z = z; x.n = n; x.o = o; x.e = e;
        return x;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Present a request and wait (bounded) for its handshake; returns one step into EXEC.
    task automatic do_req(input string tag, input int port, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [3:0] op, input exp_t e);
        int   n;
        logic rdy;
        if (port == 0) begin
            req0_A = a; req0_B = b; req0_op = op; req0_valid = 1'b1;
        end else begin
            req1_A = a; req1_B = b; req1_op = op; req1_valid = 1'b1;
        end
        #1;
        n = 0;
        rdy = (port == 0) ? req0_ready : req1_ready;
        while (!rdy && n < 10) begin
            tick();
            n++;
            rdy = (port == 0) ? req0_ready : req1_ready;
        end
        check({tag, ".ready"}, 32'(rdy), 32'd1);
        check({tag, ".other_ready"}, 32'((port == 0) ? req1_ready : req0_ready), 32'd0);
        sb.push_back(e);
        tick();
        if (port == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
        check({tag, ".alu_A"}, 32'(alu_A), 32'(a));
        check({tag, ".alu_B"}, 32'(alu_B), 32'(b));
    endtask

    // Called in EXEC; checks response at T+2, holds it for 'hold' extra cycles, then handshakes.
    task automatic get_resp(input string tag, input logic [3:0] exp_op, input int hold);
        exp_t e;
        check({tag, ".alu_op"}, 32'(alu_op), 32'(exp_op));
        check({tag, ".valid_exec"}, 32'(resp_valid), 32'd0);
        tick();
        check({tag, ".valid"}, 32'(resp_valid), 32'd1);
        check({tag, ".sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        for (int i = 0; i <= hold; i++) begin
            check({tag, ".id"},   32'(resp_id), 32'(e.id));
            check({tag, ".R"},    32'(resp_R), 32'(e.r));
            check({tag, ".flags"}, 32'({resp_isZero, resp_isNegative, resp_ovfl, resp_err}),
                  32'({e.z, e.n, e.o, e.e}));
            check({tag, ".ready_in_resp"}, 32'({req1_ready, req0_ready}), 32'd0);
            if (i < hold) begin
                tick();
                check({tag, ".valid_held"}, 32'(resp_valid), 32'd1);
            end
        end
        resp_ready = 1'b1;
        #1;
        check({tag, ".ready_in_hs"}, 32'({req1_ready, req0_ready}), 32'd0);
        tick();
        resp_ready = 1'b0;
        check({tag, ".valid_after"}, 32'(resp_valid), 32'd0);
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with a request pending: reset dominates, outputs are zero.
        req0_valid = 1'b1;
        tick();
        tick();
        check("rst.ready0", 32'(req0_ready), 32'd0);
        check("rst.resp_valid", 32'(resp_valid), 32'd0);
        check("rst.resp", 32'({resp_id, resp_R, resp_isZero, resp_isNegative, resp_ovfl, resp_err}), 32'd0);
        check("rst.alu", 32'({alu_A, alu_B}), 32'd0);
        check("rst.alu_op", 32'(alu_op), 32'd0);
        req0_valid = 1'b0;
        Reset = 1'b0;
        tick();

        // Port 0 alone: signed overflow on ADD.
        do_req("add_ovf", 0, 16'h7FFF, 16'h0001, 4'd2, mk(1'b0, 16'h8000, 1'b0, 1'b1, 1'b1, 1'b0));
        get_resp("add_ovf", 4'd2, 0);

        // Contention after reset: port 0 first, then port 1, then port 0 again.
        do_reset();
        req1_A = 16'hF0F0; req1_B = 16'h0FF0; req1_op = 4'd0; req1_valid = 1'b1;
        do_req("cont_p0", 0, 16'h0005, 16'h0005, 4'd3, mk(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0));
        check("cont.p1_ready_exec", 32'(req1_ready), 32'd0);
        get_resp("cont_p0", 4'd3, 0);
        do_req("cont_p1", 1, 16'hF0F0, 16'h0FF0, 4'd0, mk(1'b1, 16'h00F0, 1'b0, 1'b0, 1'b0, 1'b0));
        get_resp("cont_p1", 4'd0, 0);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        check("cont2.ready0", 32'(req0_ready), 32'd1);
        check("cont2.ready1", 32'(req1_ready), 32'd0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();

        // SLT, then XOR with a stale overflow on the ALU that must be masked.
        do_req("slt", 0, 16'hFFFE, 16'h0003, 4'd7, mk(1'b0, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0));
        get_resp("slt", 4'd7, 0);
        stale_ovfl = 1'b1;
        do_req("xor_stale", 1, 16'h00FF, 16'h0F0F, 4'd4, mk(1'b1, 16'h0FF0, 1'b0, 1'b0, 1'b0, 1'b0));
        get_resp("xor_stale", 4'd4, 0);
        stale_ovfl = 1'b0;

        // Illegal opcode: ALU kept on op 0 and response reduced to err.
        do_req("illegal", 0, 16'hFFFF, 16'hFFFF, 4'd9, mk(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1));
        get_resp("illegal", 4'd0, 0);

        // Backpressure with port 1 waiting; it is accepted the cycle after release.
        do_req("bp_p0", 0, 16'h1200, 16'h0034, 4'd1, mk(1'b0, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0));
        req1_A = 16'h0002; req1_B = 16'h0003; req1_op = 4'd2; req1_valid = 1'b1;
        get_resp("bp_p0", 4'd1, 5);
        check("bp.p1_ready_next", 32'(req1_ready), 32'd1);
        do_req("bp_p1", 1, 16'h0002, 16'h0003, 4'd2, mk(1'b1, 16'h0005, 1'b0, 1'b0, 1'b0, 1'b0));
        get_resp("bp_p1", 4'd2, 0);

        // Reset during EXEC discards the transaction and restores port-0 priority.
        do_req("rst_exec", 0, 16'h0001, 16'h0002, 4'd2, mk(1'b0, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b0));
        do_reset();
        sb.delete();
        check("rst_exec.resp", 32'({resp_id, resp_R, resp_isZero, resp_isNegative, resp_ovfl, resp_err}), 32'd0);
        check("rst_exec.alu", 32'({alu_A, alu_B}), 32'd0);
        check("rst_exec.alu_op", 32'(alu_op), 32'd0);
        for (int i = 0; i < 3; i++) begin
            check("rst_exec.no_valid", 32'(resp_valid), 32'd0);
            tick();
        end
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        check("rst_exec.ready0", 32'(req0_ready), 32'd1);
        check("rst_exec.ready1", 32'(req1_ready), 32'd0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
